// File: rtl/seq_counter_ctrl_if.sv
// Request/status bundle between a stimulus source and seq_counter_ctrl.
// master drives requests and observes x/status; slave is the controller side.
interface seq_counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] limit;
    logic             en;
    logic             abort;
    logic             done_ack;
    logic [WIDTH-1:0] x;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, start_val, limit, en, abort, done_ack,
        input  x, busy, done, err
    );

    modport slave (
        input  start, start_val, limit, en, abort, done_ack,
        output x, busy, done, err
    );
endinterface

// File: rtl/seq_counter_ctrl.sv
// Sequences an up-counter x from a loaded start value to a latched limit,
// then holds done until acknowledged. Supports pause, abort and rejection.
module seq_counter_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    seq_counter_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] limit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.x    <= '0;
            limit_q  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.start_val <= bus.limit) begin
                            bus.x    <= bus.start_val;
                            limit_q  <= bus.limit;
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // abort outranks reaching the limit
                    if (bus.abort) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (bus.x == limit_q) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else if (bus.en) begin
                        bus.x <= bus.x + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.done_ack) begin
                        state    <= IDLE;
                        bus.done <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

    a_busy_done_excl: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.busy && bus.done));

    a_x_in_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == RUN) |-> (bus.x <= limit_q));

    a_x_step: assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.x != $past(bus.x)) |->
            ((bus.x == WIDTH'($past(bus.x) + 1'b1))
             || $past(state == IDLE && bus.start)));
endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed vector table, async-reset sequence and randomized run against a
// run-level reference model of the counter controller.
module tb_seq_counter_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    seq_counter_ctrl_if #(.WIDTH(8)) bus ();

    seq_counter_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        logic [7:0] sv;
        logic [7:0] lim;
        logic       en;
        logic       abort;
        logic       ack;
        logic [7:0] ex;
        logic       ebusy;
        logic       edone;
        logic       eerr;
    } vec_t;

    // reference: a run is "active" or "finished"; neither means waiting
    bit         run_active;
    bit         run_finished;
    logic [7:0] m_x;
    logic [7:0] m_lim;
    bit         m_err;

    task automatic model_reset();
        run_active   = 0;
        run_finished = 0;
        m_x          = 8'd0;
        m_lim        = 8'd0;
        m_err        = 0;
    endtask

    task automatic model_step();
        m_err = 0;
        if (run_active) begin
            if (bus.abort) run_active = 0;
            else if (m_x == m_lim) begin
                run_active   = 0;
                run_finished = 1;
            end else if (bus.en) m_x = m_x + 8'd1;
        end else if (run_finished) begin
            if (bus.done_ack) run_finished = 0;
        end else if (bus.start) begin
            if (int'(bus.start_val) > int'(bus.limit)) m_err = 1;
            else begin
                m_x        = bus.start_val;
                m_lim      = bus.limit;
                run_active = 1;
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    task automatic drive(logic s, logic [7:0] sv, logic [7:0] lim,
                         logic e, logic a, logic k);
        bus.start     = s;
        bus.start_val = sv;
        bus.limit     = lim;
        bus.en        = e;
        bus.abort     = a;
        bus.done_ack  = k;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".x"},    int'(bus.x),    int'(m_x));
        chk({tag, ".busy"}, int'(bus.busy), int'(run_active));
        chk({tag, ".done"}, int'(bus.done), int'(run_finished));
        chk({tag, ".err"},  int'(bus.err),  int'(m_err));
    endtask

    vec_t vt[$];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();

        //       st sv    lim   en ab ak  x     b  d  e
        vt.push_back('{1, 8'd3,   8'd5,   1, 0, 0, 8'd3,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd4,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd5,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd5,   0, 1, 0});
        vt.push_back('{1, 8'd0,   8'd9,   0, 0, 0, 8'd5,   0, 1, 0});
        vt.push_back('{1, 8'd9,   8'd1,   0, 0, 0, 8'd5,   0, 1, 0});
        vt.push_back('{0, 8'd0,   8'd0,   0, 0, 1, 8'd5,   0, 0, 0});
        vt.push_back('{1, 8'd7,   8'd4,   1, 0, 0, 8'd5,   0, 0, 1});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd5,   0, 0, 0});
        vt.push_back('{1, 8'd255, 8'd255, 1, 0, 0, 8'd255, 1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd255, 0, 1, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 1, 8'd255, 0, 0, 0});
        vt.push_back('{1, 8'd0,   8'd3,   1, 0, 0, 8'd0,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd1,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   0, 0, 0, 8'd1,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd2,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd3,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd3,   0, 1, 0});
        vt.push_back('{0, 8'd0,   8'd0,   0, 0, 1, 8'd3,   0, 0, 0});
        vt.push_back('{1, 8'd2,   8'd4,   1, 0, 0, 8'd2,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd3,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 0, 8'd4,   1, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 1, 0, 8'd4,   0, 0, 0});
        vt.push_back('{0, 8'd0,   8'd0,   1, 0, 1, 8'd4,   0, 0, 0});
        vt.push_back('{0, 8'd6,   8'd2,   1, 0, 0, 8'd4,   0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset.x",    int'(bus.x),    0);
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.done", int'(bus.done), 0);
        chk("reset.err",  int'(bus.err),  0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].start, vt[i].sv, vt[i].lim,
                  vt[i].en, vt[i].abort, vt[i].ack);
            step();
            chk($sformatf("vec%0d.x", i),    int'(bus.x),    int'(vt[i].ex));
            chk($sformatf("vec%0d.busy", i), int'(bus.busy), int'(vt[i].ebusy));
            chk($sformatf("vec%0d.done", i), int'(bus.done), int'(vt[i].edone));
            chk($sformatf("vec%0d.err", i),  int'(bus.err),  int'(vt[i].eerr));
        end

        // asynchronous reset mid-run, checked before any clock edge
        drive(1, 8'd0, 8'd10, 1, 0, 0);
        step();
        drive(0, 8'd0, 8'd0, 1, 0, 0);
        step();
        step();
        chk("midrun.x", int'(bus.x), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.x",    int'(bus.x),    0);
        chk("async.busy", int'(bus.busy), 0);
        chk("async.done", int'(bus.done), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 8'd0, 8'd0, 0, 0, 0);
        step();
        chk_model("postrst");

        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 12)),
                  8'($urandom_range(0, 12)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) == 0));
            step();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
